sprite_anim_mapper: RTL and testbench
=====================================

Name: sprite_anim_mapper

Overview:
- Parametrised successor to the single-sprite, full-screen mapper.
- Draws one W x H indexed-colour sprite at a runtime position on the 640x480 raster, with integer scale, multiple animation frames and a transparent colour.
- Sits between the VGA controller (DrawX/DrawY/blank) and the layer compositor, which uses sprite_on to decide priority.

Parameters:
- SPRITE_W, 16, sprite width in source pixels (power of 2).
- SPRITE_H, 16, sprite height in source pixels (power of 2).
- SCALE_LOG2, 1, on-screen scale = 2**SCALE_LOG2 (0..3).
- NUM_FRAMES, 4, animation frames stored back-to-back in ROM (power of 2, >=1).
- IDX_BITS, 3, palette index width.
- ANIM_DIV, 8, video frames per animation step (>=1).
- TRANSP_IDX, 0, palette index treated as transparent.

Ports:
- vga_clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- DrawX  in  10  current pixel column.
- DrawY  in  10  current pixel row.
- blank  in  1  1 = active video.
- pos_x  in  10  sprite top-left column (screen pixels).
- pos_y  in  10  sprite top-left row.
- anim_en  in  1  1 = auto-cycle frames; 0 = show frame_sel.
- frame_sel  in  $clog2(NUM_FRAMES)  static frame when anim_en = 0.
- red, green, blue  out  4 each  registered colour; 0 when not drawing.
- sprite_on  out  1  registered: opaque sprite pixel at this output.

Behaviour:
- Reset (async, reset_n low): red/green/blue = 0, sprite_on = 0, frame counter = 0, divider = 0, latched pos = 0, pipeline valid bits = 0.
- Frame start: cycle where DrawX == 0 && DrawY == 0 (single-cycle pulse from edge detect of that condition).
  - On frame start, pos_x/pos_y/frame_sel/anim_en are latched. Mid-frame input changes have no visible effect until the next frame: no tearing.
- Animation: on each frame start with latched anim_en = 1, divider increments.
  - When divider == ANIM_DIV-1: divider -> 0 and frame -> (frame+1) mod NUM_FRAMES (wrap from NUM_FRAMES-1 to 0).
  - With anim_en = 0: frame = latched frame_sel and divider held at 0.
  - When anim_en rises, animation resumes from frame_sel.
- Stage 0 (combinational, cycle t):
  - dx = DrawX - lpos_x, dy = DrawY - lpos_y, computed 11-bit signed.
  - hit = dx, dy >= 0 && dx < SPRITE_W << SCALE_LOG2 && dy < SPRITE_H << SCALE_LOG2 && blank.
  - ROM address = frame*W*H + (dy >> SCALE_LOG2)*W + (dx >> SCALE_LOG2).
  - Address forced to 0 when no hit.
- Stage 1 (t+1): ROM q valid (synchronous ROM, 1-cycle latency); hit delayed one cycle alongside it.
- Stage 2 (t+2): palette lookup is combinational on q.
  - hit_d && q != TRANSP_IDX: red/green/blue = palette, sprite_on = 1.
  - Otherwise: rgb = 0, sprite_on = 0.
- Total latency DrawX to outputs: exactly 2 vga_clk cycles. The VGA controller's sync signals are delayed 2 cycles upstream by the top level.
- Boundary conditions:
  - Sprite partially off right/bottom edge: clipped naturally.
  - pos_x > 639: never hits.
  - No wrap-around to the left edge, because dx is a signed compare.

Optional Feature:
- Macro SPRITE_MIRROR_EN.
- Defined: adds input port mirror_x (1 bit), latched at frame start. When set, column index = SPRITE_W-1 - (dx >> SCALE_LOG2).
- Undefined: port absent; column index unmirrored.

Decomposition:
- Package sprite_pkg holds:
  - screen constants SCREEN_W = 640, SCREEN_H = 480;
  - coordinate typedef coord_t (logic [9:0]);
  - rgb4_t struct {r, g, b};
  - function sprite_rom_addr().
- One sub-module, sprite_frame_rom: synchronous ROM, parameters DEPTH = NUM_FRAMES*W*H and IDX_BITS, plus an init-file parameter.
- Palette is a per-sprite combinational module supplied at instantiation.

Test Plan:
- Reset: reset_n low mid-line -> rgb = 0, sprite_on = 0 immediately (async); after release, frame counter = 0.
- Placement: pos = (100,50), SCALE_LOG2 = 1, anim_en = 0, frame_sel = 0, ROM texel(0,0) = idx 5.
  - DrawX 100..101, DrawY 50..51 -> palette[5] on outputs exactly 2 cycles later.
  - DrawX 99 and 132 -> sprite_on = 0.
- Transparency: texel idx 0 inside the box -> sprite_on = 0 and rgb = 0; blank = 0 inside the box -> rgb = 0.
- Animation: anim_en = 1, ANIM_DIV = 8, NUM_FRAMES = 4. Run 33 frame starts -> frame steps 0,1,2,3,0 at frame starts 8,16,24,32.
- Tearing: change pos_x from 100 to 200 at DrawY = 240 -> rows 240..479 still at 100; next frame at 200.
- Clipping: pos = (630,470) -> only DrawX 630..639 and DrawY 470..479 hit; no hit at DrawX 0 on any row.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared definitions for the sprite mapper.
//   SCREEN_W/SCREEN_H : visible raster size
//   coord_t           : 10-bit screen coordinate
//   rgb4_t            : 4-bit-per-channel colour
//   sprite_rom_addr() : linear texel address inside the frame ROM
package sprite_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb4_t;

  // Frames are stored back-to-back, each one row-major.
  function automatic int unsigned sprite_rom_addr(input int unsigned frame,
                                                  input int unsigned row,
                                                  input int unsigned col,
                                                  input int unsigned w,
                                                  input int unsigned h);
    return frame * w * h + row * w + col;
  endfunction

endpackage

// File: rtl/sprite_frame_rom.sv
// sprite_frame_rom: synchronous texel ROM, one cycle read latency.
// The contents come from the INIT_DATA image (texel i at bits
// [i*IDX_BITS +: IDX_BITS]), so no load-time file access is needed.
// Ports:
//   clk_i  : clock
//   addr_i : texel address
//   q_o    : palette index, valid the cycle after addr_i
module sprite_frame_rom #(
  parameter int DEPTH    = 1024,
  parameter int IDX_BITS = 3,
  parameter logic [DEPTH*IDX_BITS-1:0] INIT_DATA = '0,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                clk_i,
  input  logic [AW-1:0]       addr_i,
  output logic [IDX_BITS-1:0] q_o
);

  logic [IDX_BITS-1:0] mem [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_mem
    assign mem[i] = INIT_DATA[i*IDX_BITS +: IDX_BITS];
  end

  always_ff @(posedge clk_i) begin
    q_o <= mem[addr_i];
  end

endmodule

// File: rtl/sprite_palette.sv
// sprite_palette: combinational palette for this sprite.
// Ports:
//   idx_i : palette index
//   rgb_o : colour for that index (unknown indices give black)
module sprite_palette
  import sprite_pkg::*;
#(
  parameter int IDX_BITS = 3
) (
  input  logic [IDX_BITS-1:0] idx_i,
  output rgb4_t               rgb_o
);

  always_comb begin
    rgb_o = '0;
    case (int'(idx_i))
      1:       rgb_o = '{r: 4'hF, g: 4'h0, b: 4'h0};
      2:       rgb_o = '{r: 4'h0, g: 4'hF, b: 4'h0};
      3:       rgb_o = '{r: 4'h0, g: 4'h0, b: 4'hF};
      4:       rgb_o = '{r: 4'hF, g: 4'hF, b: 4'h0};
      5:       rgb_o = '{r: 4'hF, g: 4'h8, b: 4'h0};
      6:       rgb_o = '{r: 4'h0, g: 4'hF, b: 4'hF};
      7:       rgb_o = '{r: 4'hF, g: 4'hF, b: 4'hF};
      default: rgb_o = '0;
    endcase
  end

endmodule

// File: rtl/sprite_anim_mapper.sv
// sprite_anim_mapper: draws one animated, scaled, positioned sprite.
// Pipeline: stage 0 computes hit + ROM address from DrawX/DrawY, stage 1 is
// the ROM read, stage 2 registers the palette colour. Outputs trail DrawX by
// exactly two vga_clk cycles.
// Position, frame_sel and anim_en are sampled only at frame start
// (DrawX==0 && DrawY==0 rising), so a frame never tears.
// Optional macro SPRITE_MIRROR_EN: adds input mirror_x (latched at frame
// start) that flips the sprite horizontally.
// Ports:
//   vga_clk, reset_n        : pixel clock, async active-low reset
//   mirror_x                : horizontal flip (SPRITE_MIRROR_EN only)
//   DrawX, DrawY, blank     : raster position, 1 = active video
//   pos_x, pos_y            : sprite top-left on screen
//   anim_en, frame_sel      : auto-animate, or show frame_sel statically
//   red, green, blue        : registered colour, 0 when not drawing
//   sprite_on               : registered opaque-pixel flag
module sprite_anim_mapper
  import sprite_pkg::*;
#(
  parameter int SPRITE_W   = 16,
  parameter int SPRITE_H   = 16,
  parameter int SCALE_LOG2 = 1,
  parameter int NUM_FRAMES = 4,
  parameter int IDX_BITS   = 3,
  parameter int ANIM_DIV   = 8,
  parameter int TRANSP_IDX = 0,
  parameter logic [NUM_FRAMES*SPRITE_W*SPRITE_H*IDX_BITS-1:0] ROM_INIT = '0,
  localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
  input  logic               vga_clk,
  input  logic               reset_n,
`ifdef SPRITE_MIRROR_EN
  input  logic               mirror_x,
`endif
  input  coord_t             DrawX,
  input  coord_t             DrawY,
  input  logic               blank,
  input  coord_t             pos_x,
  input  coord_t             pos_y,
  input  logic               anim_en,
  input  logic [FRAME_W-1:0] frame_sel,
  output logic [3:0]         red,
  output logic [3:0]         green,
  output logic [3:0]         blue,
  output logic               sprite_on
);

  localparam int     DEPTH  = NUM_FRAMES * SPRITE_W * SPRITE_H;
  localparam int     ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int     DIV_W  = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam coord_t BOX_W  = coord_t'(SPRITE_W << SCALE_LOG2);
  localparam coord_t BOX_H  = coord_t'(SPRITE_H << SCALE_LOG2);

  // ---------------- frame-start latch and animation ----------------
  logic               origin_q;
  logic               fs;
  coord_t             lpos_x_q, lpos_x_d, lpos_y_q, lpos_y_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic [DIV_W-1:0]   div_q, div_d;
`ifdef SPRITE_MIRROR_EN
  logic               mirror_q, mirror_d;
`endif

  // One-cycle pulse on the first cycle of the raster origin.
  assign fs = (DrawX == '0) && (DrawY == '0) && !origin_q;

  // anim_en/frame_sel act only here, at frame start, so they are effectively
  // latched with the position.
  always_comb begin
    lpos_x_d = lpos_x_q;
    lpos_y_d = lpos_y_q;
    frame_d  = frame_q;
    div_d    = div_q;
`ifdef SPRITE_MIRROR_EN
    mirror_d = mirror_q;
`endif
    if (fs) begin
      lpos_x_d = pos_x;
      lpos_y_d = pos_y;
`ifdef SPRITE_MIRROR_EN
      mirror_d = mirror_x;
`endif
      if (anim_en) begin
        if (div_q == DIV_W'(ANIM_DIV - 1)) begin
          div_d   = '0;
          frame_d = (frame_q == FRAME_W'(NUM_FRAMES - 1)) ? '0 : frame_q + 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end else begin
        // Held on frame_sel, so re-enabling resumes from it.
        frame_d = frame_sel;
        div_d   = '0;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      origin_q <= 1'b0;
      lpos_x_q <= '0;
      lpos_y_q <= '0;
      frame_q  <= '0;
      div_q    <= '0;
`ifdef SPRITE_MIRROR_EN
      mirror_q <= 1'b0;
`endif
    end else begin
      origin_q <= (DrawX == '0) && (DrawY == '0);
      lpos_x_q <= lpos_x_d;
      lpos_y_q <= lpos_y_d;
      frame_q  <= frame_d;
      div_q    <= div_d;
`ifdef SPRITE_MIRROR_EN
      mirror_q <= mirror_d;
`endif
    end
  end

  // ---------------- stage 0: hit test and address ----------------
  logic signed [10:0] dx, dy;
  logic               hit;
  logic [31:0]        col, row;
  logic [ADDR_W-1:0]  rom_addr;

  always_comb begin
    // Signed offsets: a sprite right of DrawX is negative, never a wrap.
    dx  = $signed({1'b0, DrawX}) - $signed({1'b0, lpos_x_q});
    dy  = $signed({1'b0, DrawY}) - $signed({1'b0, lpos_y_q});
    hit = blank && !dx[10] && !dy[10] && (dx[9:0] < BOX_W) && (dy[9:0] < BOX_H)
          && (DrawX < coord_t'(SCREEN_W)) && (DrawY < coord_t'(SCREEN_H));
    col = 32'(dx[9:0] >> SCALE_LOG2);
    row = 32'(dy[9:0] >> SCALE_LOG2);
`ifdef SPRITE_MIRROR_EN
    if (mirror_q) col = 32'(SPRITE_W - 1) - col;
`endif
    rom_addr = '0;
    if (hit) rom_addr = ADDR_W'(sprite_rom_addr(32'(frame_q), row, col,
                                                SPRITE_W, SPRITE_H));
  end

  // ---------------- stage 1: ROM read ----------------
  logic [IDX_BITS-1:0] rom_q;
  logic                hit_q;

  sprite_frame_rom #(
    .DEPTH     (DEPTH),
    .IDX_BITS  (IDX_BITS),
    .INIT_DATA (ROM_INIT)
  ) u_rom (
    .clk_i  (vga_clk),
    .addr_i (rom_addr),
    .q_o    (rom_q)
  );

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) hit_q <= 1'b0;
    else          hit_q <= hit;
  end

  // ---------------- stage 2: palette and output register ----------------
  rgb4_t pal_rgb, rgb_d, rgb_q;
  logic  on_d, on_q;

  sprite_palette #(.IDX_BITS(IDX_BITS)) u_pal (
    .idx_i (rom_q),
    .rgb_o (pal_rgb)
  );

  always_comb begin
    rgb_d = '0;
    on_d  = 1'b0;
    if (hit_q && (rom_q != IDX_BITS'(TRANSP_IDX))) begin
      rgb_d = pal_rgb;
      on_d  = 1'b1;
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= '0;
      on_q  <= 1'b0;
    end else begin
      rgb_q <= rgb_d;
      on_q  <= on_d;
    end
  end

  assign red       = rgb_q.r;
  assign green     = rgb_q.g;
  assign blue      = rgb_q.b;
  assign sprite_on = on_q;

endmodule

// File: tb/tb_sprite_anim_mapper.sv
// Scoreboard bench for sprite_anim_mapper. The ROM image is texel
// (frame f, row r, col c) = (f + 2r + c + 5) mod 8; expected indices below
// are worked out by hand from that rule.
module tb_sprite_anim_mapper;

  localparam int W = 16, H = 16, NF = 4, IB = 3;
  localparam int ROMW = NF * W * H * IB;

  function automatic logic [ROMW-1:0] build_rom();
    logic [ROMW-1:0] v;
    v = '0;
    for (int f = 0; f < NF; f++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          v[((f * W * H) + r * W + c) * IB +: IB] = IB'((f + 2 * r + c + 5) % 8);
    return v;
  endfunction

  localparam logic [ROMW-1:0] ROM_IMG = build_rom();

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic [9:0] DrawX, DrawY, pos_x, pos_y;
  logic       blank, anim_en;
  logic [1:0] frame_sel;
  logic [3:0] red, green, blue;
  logic       sprite_on;

  sprite_anim_mapper #(
    .SPRITE_W(W), .SPRITE_H(H), .SCALE_LOG2(1), .NUM_FRAMES(NF),
    .IDX_BITS(IB), .ANIM_DIV(8), .TRANSP_IDX(0), .ROM_INIT(ROM_IMG)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .pos_x(pos_x), .pos_y(pos_y), .anim_en(anim_en),
    .frame_sel(frame_sel), .red(red), .green(green), .blue(blue),
    .sprite_on(sprite_on)
  );

  always #5 vga_clk = ~vga_clk;

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [12:0] exp;
    string       name;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  int total = 0, bad = 0;

  function automatic logic [11:0] pal(int idx);
    case (idx)
      1: return 12'hF00;
      2: return 12'h0F0;
      3: return 12'h00F;
      4: return 12'hFF0;
      5: return 12'hF80;
      6: return 12'h0FF;
      7: return 12'hFFF;
      default: return 12'h000;
    endcase
  endfunction

  // idx <= 0: no opaque pixel expected (miss or transparent index 0).
  function automatic logic [12:0] expv(int idx);
    return (idx <= 0) ? 13'h0 : {1'b1, pal(idx)};
  endfunction

  task automatic chk(string nm, logic [12:0] act, logic [12:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got on=%0b rgb=%03h, want on=%0b rgb=%03h",
               nm, act[12], act[11:0], want[12], want[11:0]);
    end
  endtask

  // One pixel per cycle; its response is due two clocks later.
  task automatic pix(int x, int y, bit b, int idx, string nm);
    @(negedge vga_clk);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    sb.push_back('{cyc + 2, expv(idx), nm});
  endtask

  task automatic fstart();
    pix(1, 0, 1'b0, -1, "fs_pre");
    pix(0, 0, 1'b0, -1, "fs");
    pix(1, 0, 1'b0, -1, "fs_post");
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge vga_clk);
    if (sb.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d responses outstanding, want 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: compare each response on the cycle it becomes visible.
  initial begin
    forever begin
      @(negedge vga_clk);
      while (sb.size() > 0 && sb[0].due <= cyc) begin
        mon_e = sb.pop_front();
        chk(mon_e.name, {sprite_on, red, green, blue}, mon_e.exp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; DrawX = 10'd1; DrawY = 10'd0; blank = 1'b0;
    pos_x = 10'd0; pos_y = 10'd0; anim_en = 1'b0; frame_sel = 2'd0;
    #3 chk("reset_state", {sprite_on, red, green, blue}, 13'h0);
    repeat (3) @(negedge vga_clk);
    reset_n = 1'b1;

    // Placement at (100,50), scale 2, static frame 0.
    pos_x = 10'd100; pos_y = 10'd50;
    fstart();
    pix(100, 50, 1, 5,  "place_100_50");
    pix(101, 51, 1, 5,  "place_101_51");
    pix(102, 50, 1, 6,  "place_col1");
    pix(100, 52, 1, 7,  "place_row1");
    pix(104, 52, 1, 1,  "place_r1c2");
    pix(131, 50, 1, 4,  "place_right_edge");
    pix(100, 81, 1, 3,  "place_bottom_edge");
    pix(99,  50, 1, -1, "miss_x99");
    pix(132, 50, 1, -1, "miss_x132");
    pix(100, 49, 1, -1, "miss_y49");
    pix(100, 82, 1, -1, "miss_y82");
    pix(100, 50, 0, -1, "blank_inside");
    pix(106, 50, 1, -1, "transp_c3");
    pix(107, 51, 1, -1, "transp_c3b");

    // Static frame selection; mid-frame frame_sel change is ignored.
    frame_sel = 2'd2; fstart(); pix(100, 50, 1, 7,  "fsel2");
    frame_sel = 2'd3; fstart(); pix(100, 50, 1, -1, "fsel3_transp");
    frame_sel = 2'd1; fstart(); pix(100, 50, 1, 6,  "fsel1");
    frame_sel = 2'd2;           pix(100, 50, 1, 6,  "fsel_midframe_hold");

    // Animation: frame advances every 8th frame start.
    frame_sel = 2'd0; fstart();
    anim_en = 1'b1;
    for (int n = 1; n <= 33; n++) begin
      int idx;
      fstart();
      idx = (5 + (n / 8) % 4) % 8;
      pix(101, 51, 1, (idx == 0) ? -1 : idx, $sformatf("anim_fs%0d", n));
    end
    anim_en = 1'b0;

    // Tearing: pos_x change mid-frame shows only after next frame start.
    pos_x = 10'd100; pos_y = 10'd230;
    fstart();
    pix(100, 240, 1, 7, "tear_pre");
    pos_x = 10'd200;
    pix(100, 241, 1, 7,  "tear_old_pos_kept");
    pix(200, 241, 1, -1, "tear_new_pos_not_yet");
    fstart();
    pix(200, 240, 1, 7,  "tear_new_pos");
    pix(100, 240, 1, -1, "tear_old_pos_gone");

    // Clipping at the bottom-right corner.
    pos_x = 10'd630; pos_y = 10'd470;
    fstart();
    pix(630, 470, 1, 5,  "clip_topleft");
    pix(639, 479, 1, 1,  "clip_corner");
    pix(629, 470, 1, -1, "clip_miss_x629");
    pix(630, 469, 1, -1, "clip_miss_y469");
    pix(0,   470, 1, -1, "clip_nowrap_r470");
    pix(0,   479, 1, -1, "clip_nowrap_r479");
    pix(5,   475, 1, -1, "clip_nowrap_x5");

    pos_x = 10'd700;
    fstart();
    pix(639, 475, 1, -1, "posx_gt_639");

    // Async reset mid-line while an opaque pixel is showing (frame 2).
    pos_x = 10'd100; pos_y = 10'd50; frame_sel = 2'd2;
    fstart();
    pix(101, 51, 1, 7, "prerst_a");
    pix(101, 51, 1, 7, "prerst_b");
    pix(101, 51, 1, 7, "prerst_c");
    drain();
    #2 chk("pre_reset_on", {sprite_on, red, green, blue}, expv(7));
    reset_n = 1'b0;
    #1 chk("async_reset", {sprite_on, red, green, blue}, 13'h0);
    repeat (2) @(negedge vga_clk);
    reset_n = 1'b1;
    anim_en = 1'b1;
    fstart();
    pix(101, 51, 1, 5, "post_reset_frame0");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
